// File: rtl/swc_rtu_rsp_queue.sv
// Per-port show-ahead queue between the RTU response output and the swcore input block.
// It turns an all-zero destination mask into a drop, and counts responses lost to overflow.
module swc_rtu_rsp_queue #(
  parameter int g_num_ports  = 7,
  parameter int g_prio_width = 3,
  parameter int g_depth      = 4,
  parameter int g_cnt_width  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       rtu_valid_i,
  input  logic [g_num_ports-1:0]     rtu_dst_port_mask_i,
  input  logic                       rtu_drop_i,
  input  logic [g_prio_width-1:0]    rtu_prio_i,
  output logic                       rtu_full_o,
  output logic                       swc_rsp_valid_o,
  input  logic                       swc_rsp_ack_i,
  output logic [g_num_ports-1:0]     swc_dst_port_mask_o,
  output logic                       swc_drop_o,
  output logic [g_prio_width-1:0]    swc_prio_o,
  output logic [$clog2(g_depth):0]   level_o,
  output logic [g_cnt_width-1:0]     ovf_cnt_o,
  input  logic                       ovf_clr_i
);
  localparam int AW = $clog2(g_depth);
  localparam int LW = AW + 1;
  localparam int EW = g_num_ports + 1 + g_prio_width;
  localparam logic [LW-1:0] DEPTH = LW'(g_depth);

  logic [1:0]                    rst_sync_q;
  logic                          rst_n;
  logic [g_depth-1:0][EW-1:0]    mem_q;
  logic [EW-1:0]                 head_q, head_d, wdata;
  logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]                 count_q, count_d;
  logic [g_cnt_width-1:0]        ovf_q, ovf_d;
  logic                          push, pop, ovf;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign rtu_full_o = (count_q == DEPTH);
  assign push       = rtu_valid_i & ~rtu_full_o;
  assign ovf        = rtu_valid_i &  rtu_full_o;
  assign pop        = (count_q != '0) & swc_rsp_ack_i;

  always_comb begin
    wdata = {rtu_dst_port_mask_i, rtu_drop_i, rtu_prio_i};
    if (rtu_dst_port_mask_i == '0 && !rtu_drop_i)
      wdata = {{g_num_ports{1'b0}}, 1'b1, rtu_prio_i};
  end

  always_comb begin
    count_d = count_q + LW'(push) - LW'(pop);
    // Head register tracks the entry that will sit at rd_ptr after this edge.
    head_d  = head_q;
    if (pop && count_q > LW'(1))
      head_d = mem_q[rd_ptr_q + AW'(1)];
    else if (push && (count_q == '0 || (pop && count_q == LW'(1))))
      head_d = wdata;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr_i)                 ovf_d = '0;
    else if (ovf && ovf_q != '1)   ovf_d = ovf_q + g_cnt_width'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  assign swc_rsp_valid_o = (count_q != '0);
  assign {swc_dst_port_mask_o, swc_drop_o, swc_prio_o} = head_q;
  assign level_o   = count_q;
  assign ovf_cnt_o = ovf_q;

endmodule

// File: doc/swc_rtu_rsp_queue.md
Name: swc_rtu_rsp_queue

Overview:
- Per-port buffer between the routing table unit (RTU) response output and the switch core's rtu_rsp_valid/rtu_rsp_ack/dst_port_mask/drop/prio inputs; one instance per switch port.
- Decouples RTU response timing from swcore input-block acceptance by queueing up to g_depth responses, show-ahead, with a valid/ack handshake toward the core.
- Sanitises responses (zero mask forced to drop) and counts responses lost to overflow.

Parameters:
g_num_ports, 7, number of switch ports; width of the destination port mask
g_prio_width, 3, width of the priority field
g_depth, 4, queue entries; power of two, at least 2
g_cnt_width, 16, width of the overflow counter

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
rtu_valid_i  in  1  RTU presents a response this cycle (single-cycle strobe per response)
rtu_dst_port_mask_i  in  g_num_ports  destination port mask
rtu_drop_i  in  1  drop frame
rtu_prio_i  in  g_prio_width  frame priority
rtu_full_o  out  1  queue full; RTU must hold off
swc_rsp_valid_o  out  1  head entry valid toward swcore
swc_rsp_ack_i  in  1  swcore consumed head entry
swc_dst_port_mask_o  out  g_num_ports  head entry mask
swc_drop_o  out  1  head entry drop
swc_prio_o  out  g_prio_width  head entry priority
level_o  out  log2(g_depth)+1  current occupancy
ovf_cnt_o  out  g_cnt_width  responses discarded on overflow, saturating
ovf_clr_i  in  1  synchronous clear of ovf_cnt_o

Behaviour:
- Reset (async assert, sync deassert inside block): count=0, rd/wr pointers=0, ovf_cnt_o=0, rtu_full_o=0, swc_rsp_valid_o=0, swc_dst_port_mask_o=0, swc_drop_o=0, swc_prio_o=0, level_o=0. Reset mid-operation discards all stored entries; no partial pop/push completes.
- Storage: g_depth x (g_num_ports+1+g_prio_width) register array; write pointer and read pointer each log2(g_depth) bits, wrapping modulo g_depth; separate count register 0..g_depth.
- Push: rtu_valid_i=1 and count<g_depth. Entry written at wr_ptr; wr_ptr increments.
- Sanitise on push: if rtu_dst_port_mask_i==0 and rtu_drop_i==0, store drop=1 and mask=0. All other combinations are stored unchanged.
- Overflow: rtu_valid_i=1 while count==g_depth. The entry is discarded, ovf_cnt_o increments by 1 and saturates at 2^g_cnt_width-1. Fullness is judged on the registered count, so a push on a cycle that pops from a full queue is also discarded.
- rtu_full_o = (count==g_depth), a registered-count decode.
- Output (show-ahead): swc_rsp_valid_o=(count!=0), registered. Head fields come from the array at rd_ptr and are stable while valid=1 and ack=0.
- Pop: swc_rsp_valid_o=1 and swc_rsp_ack_i=1. rd_ptr increments; the next entry is visible the following cycle. Ack while valid=0 is ignored.
- Latency: a push into an empty queue gives swc_rsp_valid_o=1 on the next clock edge (1 cycle).
- Throughput: back-to-back pops sustain 1 entry/cycle.
- Simultaneous push and pop with 0<count<g_depth: count is unchanged, both pointers advance.
- When count==0, the output fields hold their last value; consumers use them only while valid=1.
- level_o = count.
- ovf_cnt_o: ovf_clr_i has priority over an increment on the same cycle, giving a result of 0.

Test Plan:
- Reset, push 1 response (mask=7'b0000110, drop=0, prio=5) -> valid_o=1 one cycle later with identical fields; ack -> valid_o=0 next cycle, level_o=0.
- Push 4 responses (prio 0..3) with no ack, g_depth=4 -> rtu_full_o=1, level_o=4; a 5th push is discarded and ovf_cnt_o=1. Ack 4 times -> prio out 0,1,2,3 in order, then valid_o=0.
- Push with mask=0, drop=0 -> output drop=1, mask=0. Push with mask=0, drop=1 -> unchanged.
- Steady state at level 2, push and ack every cycle for 16 cycles -> level_o stays 2, ordering preserved across pointer wrap-around.
- Full queue, push and ack on the same cycle -> push discarded, ovf_cnt_o increments, level_o=3. Preload ovf_cnt to 0xFFFF and overflow again -> stays 0xFFFF. Assert ovf_clr_i together with an overflow -> 0.
- Assert rst_n_i low for 1 cycle with 3 entries queued -> all outputs 0 immediately (asynchronous). Then push 1 -> it is the sole entry delivered.
